// File: rtl/sfilt_seq_if.sv
// Upstream sample/config bus plus downstream filter command bus of the sequencer.
interface sfilt_seq_if;
  logic        pushin;
  logic [31:0] din;
  logic        stopout;
  logic        cwe;
  logic [3:0]  caddr;
  logic [31:0] cdata;
  logic        swe;
  logic [6:0]  sdata;
  logic        clr;
  logic        pushout;
  logic [1:0]  cmd;
  logic [31:0] q;
  logic [31:0] h;

  modport master (input pushin, din, cwe, caddr, cdata, swe, sdata, clr,
                  output stopout, pushout, cmd, q, h);
  modport slave  (output pushin, din, cwe, caddr, cdata, swe, sdata, clr,
                  input stopout, pushout, cmd, q, h);
endinterface

// File: rtl/sfilt_seq.sv
// Per-sample command sequencer for the serial filter: one sample in,
// TAPS+2 beats out (first mult, mult-accs, shift/round, output).
module sfilt_seq #(
  parameter int TAPS = 8
) (
  input  logic         clk,
  input  logic         rst,
  sfilt_seq_if.master  bus
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [4:0] KSHIFT = 5'(TAPS);
  localparam logic [4:0] KLAST  = 5'(TAPS + 1);

  state_t                 state_q;
  logic [4:0]             k_q, k_d;
  logic [TAPS-1:0][31:0]  x_q, x_d, c_q, c_d;
  logic [6:0]             shamt_q;
  logic                   pushout_q;
  logic [1:0]             cmd_q, cmd_d;
  logic [31:0]            q_q, q_d, h_q, h_d;
  logic                   stop, accept, run_next;

  // Busy for every beat except the last, so a new sample lands back-to-back.
  assign stop     = (state_q == RUN) && (k_q != KLAST);
  assign accept   = bus.pushin && !stop;
  assign run_next = accept || stop;

  always_comb begin
    x_d = x_q;
    if (!stop && bus.clr) x_d = '0;
    if (accept)           x_d = {x_d[TAPS-2:0], bus.din};
  end

  always_comb begin
    c_d = c_q;
    for (int i = 0; i < TAPS; i++)
      if (bus.cwe && bus.caddr == 4'(i)) c_d[i] = bus.cdata;
  end

  // Next beat reads the post-shift delay line but pre-write coefficients.
  always_comb begin
    k_d   = accept ? 5'd0 : k_q + 5'd1;
    cmd_d = 2'd0;
    q_d   = '0;
    h_d   = '0;
    if (k_d == 5'd0)        cmd_d = 2'd0;
    else if (k_d < KSHIFT)  cmd_d = 2'd1;
    else if (k_d == KSHIFT) begin
      cmd_d = 2'd2;
      h_d   = {25'b0, shamt_q};
    end else                cmd_d = 2'd3;
    for (int i = 0; i < TAPS; i++)
      if (k_d == 5'(i)) begin
        q_d = x_d[i];
        h_d = c_q[i];
      end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      x_q       <= '0;
      c_q       <= '0;
      shamt_q   <= '0;
      pushout_q <= 1'b0;
      cmd_q     <= '0;
      q_q       <= '0;
      h_q       <= '0;
    end else begin
      x_q <= x_d;
      c_q <= c_d;
      if (bus.swe) shamt_q <= bus.sdata;
      if (run_next) begin
        state_q   <= RUN;
        k_q       <= k_d;
        pushout_q <= 1'b1;
        cmd_q     <= cmd_d;
        q_q       <= q_d;
        h_q       <= h_d;
      end else begin
        state_q   <= IDLE;
        k_q       <= '0;
        pushout_q <= 1'b0;
        cmd_q     <= '0;
        q_q       <= '0;
        h_q       <= '0;
      end
    end
  end

  assign bus.stopout = stop;
  assign bus.pushout = pushout_q;
  assign bus.cmd     = cmd_q;
  assign bus.q       = q_q;
  assign bus.h       = h_q;
endmodule
